// File: rtl/report_arbiter.sv
// rtl/report_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
// between report sources, with per-message locking and a stall timeout.
module report_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ack,
  input  logic                   require,
  output logic [7:0]             data,
  output logic                   valid,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOCK, SEND, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   stall_cnt;
  logic            last_q;
  logic            found;
  logic [PW-1:0]   pick;
  int              idx;

  // First requester after the last granted source, wrapping modulo NUM_SRC.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && src_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_SRC - 1);
      stall_cnt   <= '0;
      last_q      <= 1'b0;
      grant       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      data        <= 8'h00;
      src_ack     <= '0;
      timeout_err <= 1'b0;
    end else begin
      valid       <= 1'b0;
      src_ack     <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr   <= pick;
            grant <= NUM_SRC'(1) << pick;
            busy  <= 1'b1;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (require && src_valid[ptr]) begin
            data      <= src_data[8*int'(ptr) +: 8];
            valid     <= 1'b1;
            src_ack   <= grant;
            last_q    <= src_last[ptr];
            stall_cnt <= '0;
            state     <= SEND;
          end else if (!src_valid[ptr]) begin
            // Only an absent byte counts as a stall; UART back-pressure does not.
            if (stall_cnt >= STALL_LIMIT) begin
              stall_cnt   <= '0;
              grant       <= '0;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + CW'(1);
            end
          end
        end
        SEND: state <= HOLD;
        HOLD: begin
          if (last_q) begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= LOCK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_report_arbiter.sv
// tb/tb_report_arbiter.sv - self-checking bench for report_arbiter with
// directed scenarios and randomized round-robin message traffic.
module tb_report_arbiter;

  localparam int NS = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS-1:0]   src_valid;
  logic [8*NS-1:0] src_data;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ack;
  logic            require;
  logic [7:0]      data;
  logic            valid;
  logic [NS-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  always #5 clk = ~clk;

  report_arbiter #(.NUM_SRC(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ack(src_ack), .require(require), .data(data),
    .valid(valid), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct { logic [7:0] d; logic [1:0] g; int c; } rec_t;

  rec_t       obs[$];
  logic [9:0] exp_q[$];
  int         tmo_cyc[$];
  logic [1:0] tmo_g[$];
  logic [8:0] sq[2][$];
  logic [8:0] snap[2][$];
  logic [1:0] en;
  bit         rand_req;
  int         cyc, last_vcyc, first_g1;
  int         checks, errors;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drive_src();
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      if (en[i] && sq[i].size() > 0) begin
        e = sq[i][0];
        src_valid[i]       = 1'b1;
        src_data[8*i +: 8] = e[7:0];
        src_last[i]        = e[8];
      end else begin
        src_valid[i]       = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i]        = 1'b0;
      end
    end
    if (rand_req) require = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    rec_t r;
    logic [8:0] e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!rst) begin
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("busy_vs_grant", busy, |grant);
      check("ack_vs_valid", src_ack, valid ? grant : 2'b00);
      if (valid) begin
        check("valid_spacing", (last_vcyc < 0 || cyc - last_vcyc >= 3), 1);
        last_vcyc = cyc;
        r.d = data; r.g = grant; r.c = cyc;
        obs.push_back(r);
      end
      if (timeout_err) begin
        tmo_cyc.push_back(cyc);
        tmo_g.push_back(grant);
      end
      if (grant == 2'b10 && first_g1 < 0) first_g1 = cyc;
    end
    for (int i = 0; i < 2; i++)
      if (src_ack[i] && sq[i].size() > 0) e = sq[i].pop_front();
    drive_src();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    rand_req = 1'b0;
    require = 1'b1;
    en = 2'b11;
    for (int i = 0; i < 2; i++) begin
      sq[i].delete();
      snap[i].delete();
    end
    drive_src();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs.delete(); exp_q.delete(); tmo_cyc.delete(); tmo_g.delete();
    last_vcyc = -1;
    first_g1 = -1;
  endtask

  task automatic push_byte(input int s, input logic [7:0] b, input bit l);
    sq[s].push_back({l, b});
    snap[s].push_back({l, b});
  endtask

  task automatic exp_push(input logic [1:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic run_idle(input int max);
    bit done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      tick();
      if (sq[0].size() == 0 && sq[1].size() == 0 && grant == 2'b00) done = 1'b1;
    end
    check("run_bound", done, 1);
  endtask

  // Whole messages leave atomically; the next owner is the nearest source
  // after the previous owner that still has a message queued.
  task automatic build_rr();
    logic [8:0] m[2][$];
    logic [8:0] b;
    int turn, s;
    m[0] = snap[0];
    m[1] = snap[1];
    exp_q.delete();
    turn = 0;
    while (m[0].size() > 0 || m[1].size() > 0) begin
      s = (m[turn].size() > 0) ? turn : 1 - turn;
      b = m[s].pop_front();
      exp_push(2'(1 << s), b[7:0]);
      while (!b[8] && m[s].size() > 0) begin
        b = m[s].pop_front();
        exp_push(2'(1 << s), b[7:0]);
      end
      turn = 1 - s;
    end
  endtask

  task automatic compare_exp(input string tag);
    int n;
    check({tag, "_count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), {obs[i].g, obs[i].d}, exp_q[i]);
  endtask

  initial begin
    int c, nm, len;
    checks = 0; errors = 0; cyc = 0; last_vcyc = -1; first_g1 = -1;
    en = 2'b11; rand_req = 1'b0; require = 1'b0;
    src_valid = '0; src_data = '0; src_last = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ack", src_ack, 0);
    check("rst_timeout", timeout_err, 0);

    // Single source, three-byte message
    reset_dut();
    push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h0A, 1);
    drive_src();
    run_idle(200);
    build_rr();
    compare_exp("single");
    if (obs.size() >= 3) begin
      check("single_gap01", obs[1].c - obs[0].c, 3);
      check("single_gap12", obs[2].c - obs[1].c, 3);
    end
    check("single_end_grant", grant, 0);
    check("single_end_busy", busy, 0);

    // Fairness: two 2-byte messages per source
    reset_dut();
    push_byte(0, 8'h11, 0); push_byte(0, 8'h12, 1); push_byte(0, 8'h13, 0); push_byte(0, 8'h14, 1);
    push_byte(1, 8'h21, 0); push_byte(1, 8'h22, 1); push_byte(1, 8'h23, 0); push_byte(1, 8'h24, 1);
    drive_src();
    run_idle(400);
    build_rr();
    compare_exp("fair");

    // Atomicity: src1 requests after src0's first byte
    reset_dut();
    en = 2'b01;
    push_byte(0, 8'h31, 0); push_byte(0, 8'h32, 0); push_byte(0, 8'h33, 0); push_byte(0, 8'h34, 1);
    push_byte(1, 8'h51, 0); push_byte(1, 8'h52, 1);
    drive_src();
    for (int n = 0; n < 50 && obs.size() == 0; n++) tick();
    check("atom_first", obs.size(), 1);
    en = 2'b11;
    drive_src();
    run_idle(400);
    exp_push(2'b01, 8'h31); exp_push(2'b01, 8'h32); exp_push(2'b01, 8'h33); exp_push(2'b01, 8'h34);
    exp_push(2'b10, 8'h51); exp_push(2'b10, 8'h52);
    compare_exp("atom");

    // Back-pressure: require low for 50 cycles
    reset_dut();
    require = 1'b0;
    push_byte(0, 8'h77, 1);
    drive_src();
    repeat (50) tick();
    check("bp_no_valid", obs.size(), 0);
    check("bp_no_timeout", tmo_cyc.size(), 0);
    check("bp_grant", grant, 2'b01);
    c = cyc;
    require = 1'b1;
    tick();
    check("bp_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      check("bp_latency", obs[0].c, c + 1);
      check("bp_data", obs[0].d, 8'h77);
    end
    run_idle(50);

    // Timeout: src0 stalls after a non-last byte
    reset_dut();
    push_byte(0, 8'h55, 0);
    push_byte(1, 8'h61, 0); push_byte(1, 8'h62, 1);
    drive_src();
    run_idle(400);
    check("tmo_pulses", tmo_cyc.size(), 1);
    if (tmo_cyc.size() >= 1 && obs.size() >= 1) begin
      check("tmo_time", tmo_cyc[0], obs[0].c + 3 + TO - 1);
      check("tmo_grant", tmo_g[0], 2'b00);
      check("tmo_regrant", first_g1, tmo_cyc[0] + 1);
    end
    exp_push(2'b01, 8'h55); exp_push(2'b10, 8'h61); exp_push(2'b10, 8'h62);
    compare_exp("tmo");

    // Reset during the HOLD cycle of src1's second byte
    reset_dut();
    en = 2'b10;
    push_byte(1, 8'h81, 0); push_byte(1, 8'h82, 0); push_byte(1, 8'h83, 1);
    push_byte(0, 8'h91, 1);
    drive_src();
    for (int n = 0; n < 50 && obs.size() < 2; n++) tick();
    check("rmm_two_bytes", obs.size(), 2);
    tick();
    check("rmm_pre_grant", grant, 2'b10);
    rst = 1'b1;
    #1;
    check("rmm_grant", grant, 0);
    check("rmm_busy", busy, 0);
    check("rmm_valid", valid, 0);
    check("rmm_data", data, 0);
    check("rmm_ack", src_ack, 0);
    check("rmm_timeout", timeout_err, 0);
    en = 2'b11;
    drive_src();
    @(negedge clk);
    rst = 1'b0;
    last_vcyc = -1;
    tick();
    check("rmm_first_grant", grant, 2'b01);
    run_idle(200);
    exp_push(2'b10, 8'h81); exp_push(2'b10, 8'h82);
    exp_push(2'b01, 8'h91); exp_push(2'b10, 8'h83);
    compare_exp("rmm");

    // Randomized messages with random UART readiness
    for (int it = 0; it < 3; it++) begin
      reset_dut();
      rand_req = 1'b1;
      for (int s = 0; s < 2; s++) begin
        nm = $urandom_range(2, 4);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), b == len - 1);
        end
      end
      drive_src();
      run_idle(3000);
      build_rr();
      compare_exp($sformatf("rand%0d", it));
    end
    rand_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/report_arbiter.md
# report_arbiter

Round-robin arbiter that shares the single UART byte transmitter between several report sources, such as the ASCII statistics reporter and future debug/trace reporters. It sits between the sources and the UART transmitter on the FPGA verification platform. Each source's message goes out atomically: once granted, a source keeps the UART until it sends its last byte or stalls past a timeout. Per-byte hand-off uses the transmitter's require/valid handshake.

## Interface
- NUM_SRC, 2: number of requesting sources (2..8)
- TIMEOUT_CYCLES, 1_000_000: consecutive stall cycles of a granted source before forced release (≥2)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- src_valid  in  NUM_SRC  source i has a byte ready on its data slice
- src_data  in  8*NUM_SRC  byte of source i at bits [8i+7:8i]
- src_last  in  NUM_SRC  current byte of source i is the last of its message
- src_ack  out  NUM_SRC  one-cycle pulse: source i's byte consumed; source presents next byte (or drops valid) the following cycle
- require  in  1  UART transmitter idle and ready for a byte (level)
- data  out  8  byte to UART, valid only while valid=1
- valid  out  1  one-cycle pulse transferring data to UART
- grant  out  NUM_SRC  one-hot current owner, all-zero when idle
- busy  out  1  a message is in progress (grant≠0)
- timeout_err  out  1  one-cycle pulse when a grant is forcibly released

## Operation
- States: IDLE, LOCK, SEND, HOLD.
- Round-robin pointer ptr holds the index of the last granted source. The search order is ptr+1, ptr+2, … modulo NUM_SRC.
- IDLE: if any src_valid is set, grant the first requester in search order, set ptr to it, go to LOCK. Otherwise stay.
- LOCK: clear the stall counter when a byte is sent.
  - If require=1 and src_valid[g]=1: register data=src_data[g], valid=1, src_ack[g]=1, latch src_last[g]. Go to SEND.
  - Else if src_valid[g]=0: increment the stall counter. When it reaches TIMEOUT_CYCLES, clear grant, pulse timeout_err, go to IDLE.
  - require=0 with src_valid[g]=1 is not a stall; the counter holds.
- SEND: valid and src_ack drop. Go to HOLD. This gives the UART one cycle to drop require.
- HOLD: if the latched last flag is set, clear grant and go to IDLE. Otherwise go to LOCK.
- Grant changes only on IDLE→LOCK or on release. Requests raised by other sources during a message are ignored until release.
- src_last on a byte is sampled only at the moment of transfer.
- Stall counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Reset values (asynchronous, immediate): state IDLE, ptr=NUM_SRC-1 (source 0 wins first), grant=0, busy=0, valid=0, data=0x00, src_ack=0, timeout_err=0, stall counter 0.
- All outputs are registered. busy equals |grant.
- Grant latency: src_valid high at edge k in IDLE → grant visible after edge k.
- Byte latency: require & src_valid[g] sampled at edge k in LOCK → valid/src_ack high for exactly the cycle after edge k.
- Minimum byte spacing is 3 cycles (LOCK→SEND→HOLD→LOCK). Minimum message gap is 1 IDLE cycle.
- Reset mid-message: the message is abandoned with no further valid. After reset release the first grant goes to the lowest-index requester.
- valid is never high for two consecutive cycles. Exactly one src_ack pulse occurs per valid pulse, on the granted source.

## Test plan
- Single source: after reset, src0 presents 0x41, 0x42, 0x0A (last) with require held 1 → three valid pulses carrying 0x41, 0x42, 0x0A, each with src_ack=01 in the same cycle and spaced 3 cycles apart. grant=01 throughout, then grant=00 and busy=0.
- Fairness: src0 and src1 request continuously, each sending 2-byte messages → order of messages is src0, src1, src0, src1. Bytes of different messages are never interleaved.
- Atomicity: src1 raises src_valid after the first byte of src0's 4-byte message → all 4 src0 bytes go out before grant switches to 10.
- Back-pressure: require held 0 for 50 cycles while src0 is valid → no valid pulse and no timeout_err. Require rises at edge k → valid in the cycle after edge k.
- Timeout (TIMEOUT_CYCLES=16): src0 sends 1 non-last byte then drops src_valid while src1 requests → timeout_err pulses once, 16 cycles after the stall begins. grant goes 01→00→10 and src1's message is sent.
- Reset mid-message: assert rst during the HOLD cycle of src1's second byte → all outputs 0 immediately. After release with both sources requesting, the first grant is 01.
